// File: rtl/uart_tx_arbiter.sv
// Shares the board UART TX pin between the CPU and the LiteDRAM debug UART.
// Ownership moves only on frame boundaries; a stuck line forces a guarded handover.
module uart_tx_arbiter #(
  parameter int BIT_CYCLES   = 434,
  parameter int IDLE_BITS    = 11,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sel,
  input  logic       i_ram_init_done,
  input  logic       i_cpu_tx,
  input  logic       i_dram_tx,
  output logic       o_uart_tx,
  output logic       o_owner,
  output logic       o_busy,
  output logic [7:0] o_switch_cnt,
  output logic [1:0] o_dbg_state   // 0 = OWN, 1 = WAIT, 2 = GUARD
);

  localparam int IDLE = BIT_CYCLES * IDLE_BITS;
  localparam int TMO  = BIT_CYCLES * TIMEOUT_BITS;
  localparam int IW   = (IDLE > 1) ? $clog2(IDLE) : 1;
  localparam int TW   = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);

  localparam logic [1:0] S_OWN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  logic          r_sel_meta;
  logic          r_sel_sync;
  logic          r_init_meta;
  logic          r_init_sync;
  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_uart_tx;
  logic [7:0]    r_switch_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic [TW-1:0] r_tmo_cnt;

  logic          w_req;
  logic          w_lines_idle;
  logic [7:0]    w_switch_next;

  // LiteDRAM keeps the pin until its init is seen, whatever the switch says.
  assign w_req         = ~r_init_sync | r_sel_sync;
  assign w_lines_idle  = i_cpu_tx & i_dram_tx;
  assign w_switch_next = (r_switch_cnt == 8'hFF) ? r_switch_cnt : r_switch_cnt + 8'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel_meta  <= 1'b0;
      r_sel_sync  <= 1'b0;
      r_init_meta <= 1'b0;
      r_init_sync <= 1'b0;
    end else begin
      r_sel_meta  <= i_sel;
      r_sel_sync  <= r_sel_meta;
      r_init_meta <= i_ram_init_done;
      r_init_sync <= r_init_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_uart_tx <= 1'b1;
    end else if (r_state == S_GUARD) begin
      r_uart_tx <= 1'b1;
    end else begin
      r_uart_tx <= r_owner ? i_dram_tx : i_cpu_tx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_OWN;
      r_owner      <= 1'b1;
      r_switch_cnt <= 8'd0;
      r_idle_cnt   <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      case (r_state)
        S_OWN: begin
          r_idle_cnt <= '0;
          r_tmo_cnt  <= '0;
          if (w_req != r_owner) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A withdrawn request wins even if the line went idle or the timer expired.
          if (w_req == r_owner) begin
            r_state    <= S_OWN;
            r_idle_cnt <= '0;
            r_tmo_cnt  <= '0;
          end else if (w_lines_idle && (r_idle_cnt == IDLE_LAST)) begin
            r_owner      <= w_req;
            r_switch_cnt <= w_switch_next;
            r_state      <= S_OWN;
            r_idle_cnt   <= '0;
            r_tmo_cnt    <= '0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_owner      <= w_req;
            r_switch_cnt <= w_switch_next;
            r_state      <= S_GUARD;
            r_idle_cnt   <= '0;
            r_tmo_cnt    <= '0;
          end else begin
            r_tmo_cnt  <= r_tmo_cnt + TW'(1);
            r_idle_cnt <= w_lines_idle ? r_idle_cnt + IW'(1) : '0;
          end
        end
        S_GUARD: begin
          // Hold the pin high one full idle window so the receiver can resync.
          if (r_idle_cnt == IDLE_LAST) begin
            r_state    <= S_OWN;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end
        default: begin
          r_state    <= S_OWN;
          r_idle_cnt <= '0;
          r_tmo_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_uart_tx    = r_uart_tx;
  assign o_owner      = r_owner;
  assign o_busy       = (r_state != S_OWN);
  assign o_switch_cnt = r_switch_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios against a
// behavioural ownership model, plus hand-computed literal expectations.
module tb_uart_tx_arbiter;

  localparam int BIT_CYCLES   = 4;
  localparam int IDLE_BITS    = 2;
  localparam int TIMEOUT_BITS = 8;
  localparam int IDLE         = BIT_CYCLES * IDLE_BITS;     // 8
  localparam int TMO          = BIT_CYCLES * TIMEOUT_BITS;  // 32

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       init_done = 1'b0;
  logic       cpu_tx = 1'b1;
  logic       dram_tx = 1'b1;
  logic       uart_tx;
  logic       owner;
  logic       busy;
  logic [7:0] switch_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  uart_tx_arbiter #(
    .BIT_CYCLES  (BIT_CYCLES),
    .IDLE_BITS   (IDLE_BITS),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sel          (sel),
    .i_ram_init_done(init_done),
    .i_cpu_tx       (cpu_tx),
    .i_dram_tx      (dram_tx),
    .o_uart_tx      (uart_tx),
    .o_owner        (owner),
    .o_busy         (busy),
    .o_switch_cnt   (switch_cnt),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Ownership expressed as: pending request age, length of the current quiet run,
  // and remaining guard cycles. Synchronizers are modelled as a 2-deep history.
  bit m_sel_h1 = 1'b0, m_sel_h2 = 1'b0, m_init_h1 = 1'b0, m_init_h2 = 1'b0;
  bit m_owner = 1'b1, m_tx = 1'b1, m_waiting = 1'b0, m_req;
  int m_cnt = 0, m_wait_age = 0, m_quiet = 0, m_guard_left = 0;

  task automatic model_reset();
    m_sel_h1 = 0; m_sel_h2 = 0; m_init_h1 = 0; m_init_h2 = 0;
    m_owner = 1; m_tx = 1; m_waiting = 0; m_cnt = 0;
    m_wait_age = 0; m_quiet = 0; m_guard_left = 0;
  endtask

  task automatic model_handover();
    m_owner   = m_req;
    m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_waiting = 0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      model_reset();
    end else begin
      m_req = !m_init_h2 || m_sel_h2;
      m_tx  = (m_guard_left > 0) ? 1'b1 : (m_owner ? dram_tx : cpu_tx);
      if (m_guard_left > 0) begin
        m_guard_left--;
      end else if (!m_waiting) begin
        if (m_req != m_owner) begin
          m_waiting = 1; m_wait_age = 0; m_quiet = 0;
        end
      end else if (m_req == m_owner) begin
        m_waiting = 0;
      end else begin
        m_wait_age++;
        m_quiet = (cpu_tx && dram_tx) ? m_quiet + 1 : 0;
        if (m_quiet >= IDLE) begin
          model_handover();
        end else if (m_wait_age >= TMO) begin
          model_handover();
          m_guard_left = IDLE;
        end
      end
      m_sel_h2 = m_sel_h1;   m_sel_h1 = sel;
      m_init_h2 = m_init_h1; m_init_h1 = init_done;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_tx",     uart_tx,    m_tx);
      check("model_owner",  owner,      m_owner);
      check("model_busy",   busy,       (m_waiting || m_guard_left > 0));
      check("model_cnt",    switch_cnt, m_cnt);
      check("model_state",  dbg_state,  (m_guard_left > 0) ? 2 : (m_waiting ? 1 : 0));
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    tick(3);
    rst = 1'b0;

    // 1: LiteDRAM owns the pin while init is pending.
    tick(50);
    check("t1_owner", owner, 1);
    check("t1_busy",  busy,  0);
    check("t1_cnt",   switch_cnt, 0);
    check("t1_tx",    uart_tx, 1);

    // 2: init completes with sel=0 -> clean handover to the cpu.
    init_done = 1'b1;
    tick(2);
    check("t2_busy_early", busy, 0);
    tick(1);
    check("t2_busy_rise", busy, 1);
    tick(7);
    check("t2_owner_hold", owner, 1);
    tick(1);
    check("t2_owner_cpu", owner, 0);
    check("t2_cnt", switch_cnt, 1);
    check("t2_busy_done", busy, 0);
    cpu_tx = 1'b0;
    tick(1);
    check("t2_cpu_pulse", uart_tx, 0);
    cpu_tx = 1'b1;
    tick(1);
    check("t2_cpu_release", uart_tx, 1);

    // 3: back to litedram, then a request blocked by periodic dram activity.
    sel = 1'b1;
    tick(12);
    check("t3_owner_dram", owner, 1);
    check("t3_cnt_a", switch_cnt, 2);
    sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dram_tx = (i % 5 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    dram_tx = 1'b1;
    check("t3_still_waiting", busy, 1);
    check("t3_no_handover", owner, 1);
    tick(3);
    check("t3_owner_before", owner, 1);
    tick(1);
    check("t3_owner_after", owner, 0);
    check("t3_cnt_b", switch_cnt, 3);

    // 4: stuck dram line forces a timeout and a guard window.
    sel = 1'b1;
    tick(12);
    check("t4_owner_dram", owner, 1);
    for (int i = 0; i < 50; i++) begin
      if (i == 34) begin
        check("t4_wait_owner", owner, 1);
        check("t4_wait_busy",  busy,  1);
      end
      if (i == 35) begin
        check("t4_forced_owner", owner, 0);
        check("t4_forced_cnt",   switch_cnt, 5);
        check("t4_last_dram_bit", uart_tx, 0);
      end
      if (i >= 36 && i <= 43) check("t4_guard_tx", uart_tx, 1);
      if (i == 42) check("t4_guard_busy", busy, 1);
      if (i == 43) check("t4_guard_exit", busy, 0);
      sel     = 1'b0;
      dram_tx = (i < 40) ? 1'b0 : 1'b1;
      cpu_tx  = (i < 44) ? i[0] : 1'b1;
      tick(1);
    end

    // 5: request withdrawn inside WAIT.
    sel = 1'b1;
    tick(12);
    check("t5_owner_dram", owner, 1);
    sel = 1'b0;
    tick(4);
    sel = 1'b1;
    tick(1);
    check("t5_busy_mid", busy, 1);
    tick(2);
    check("t5_busy_end", busy, 0);
    check("t5_owner",    owner, 1);
    check("t5_cnt",      switch_cnt, 6);

    // 6: saturate the counter, then reset in the middle of a guard window.
    for (int j = 0; j < 252; j++) begin
      sel = (j % 2 == 0) ? 1'b0 : 1'b1;
      tick(12);
    end
    check("t6_sat", switch_cnt, 255);
    check("t6_owner", owner, 1);
    sel    = 1'b0;
    cpu_tx = 1'b0;
    tick(36);
    check("t6_guard_busy",  busy,  1);
    check("t6_guard_owner", owner, 0);
    check("t6_sat_hold",    switch_cnt, 255);
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tx",    uart_tx, 1);
    check("t6_rst_owner", owner, 1);
    check("t6_rst_cnt",   switch_cnt, 0);
    check("t6_rst_busy",  busy, 0);
    tick(2);
    rst    = 1'b0;
    cpu_tx = 1'b1;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
